ram_bytes_ctrl: RTL and testbench

Parametrised, byte-addressable data/program RAM for the multi-cycle RISC-V core, replacing the fixed 128-word memory. Adds a request/ready/rvalid handshake, byte-lane write strobes for sb/sh/sw, a hardware zero-clear sequence after reset, and access-error reporting. An optional memory-mapped output register drives the board-level `toggle_value` port.

---
 rtl/ram_bytes_ctrl.sv | 159 +++++++++++++++
 tb/tb_ram_bytes_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ram_bytes_ctrl.sv
// Byte-addressable word RAM with req/ready/rvalid handshake, write strobes, zero-clear after reset
// and error reporting. Define RAM_MMIO_EN to add the memory-mapped toggle_value output register.
module ram_bytes_ctrl #(
  parameter int          DEPTH_WORDS = 128,
  parameter logic [31:0] MMIO_ADDR   = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  input  logic [3:0]  be,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rd,
  output logic        err,
  output logic [31:0] toggle_value
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [IDX_W:0] CLR_LAST = (IDX_W + 1)'(DEPTH_WORDS - 1);

`ifdef RAM_MMIO_EN
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  lanes);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  state_e           state_q, state_d;
  logic [IDX_W:0]   clr_idx_q, clr_idx_d;
  logic             rvalid_q, rvalid_d;
  logic [31:0]      rd_q, rd_d;
  logic             err_q, err_d;

  logic [31:0]      mem_q [DEPTH_WORDS];
  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      mem_wdata;

  logic             misaligned, mmio_sel, ram_sel;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      ram_old, ram_merged;
  logic [31:0]      mmio_rdata;

  assign misaligned = (a[1:0] != 2'b00);
  assign mmio_sel   = MMIO_EN && (a == MMIO_ADDR);
  assign ram_sel    = (a < RAM_BYTES);
  assign word_idx   = a[IDX_W+1:2];
  assign ram_old    = mem_q[word_idx];
  assign ram_merged = merge_lanes(ram_old, wd, be);

  // NOTE: every variable driven here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    rvalid_d  = 1'b0;
    rd_d      = rd_q;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_idx   = clr_idx_q[IDX_W-1:0];
    mem_wdata = '0;

    unique case (state_q)
      ST_CLEAR: begin
        mem_we = 1'b1;
        if (clr_idx_q == CLR_LAST) begin
          state_d   = ST_IDLE;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (req) begin
          rvalid_d = 1'b1;
          if (misaligned) begin
            err_d = 1'b1;
            rd_d  = '0;
          end else if (mmio_sel) begin
            rd_d = we ? merge_lanes(mmio_rdata, wd, be) : mmio_rdata;
          end else if (ram_sel) begin
            // Write-first: the response carries the merged word that lands in the array.
            rd_d      = we ? ram_merged : ram_old;
            mem_we    = we;
            mem_idx   = word_idx;
            mem_wdata = ram_merged;
          end else begin
            err_d = 1'b1;
            rd_d  = '0;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      rvalid_q  <= 1'b0;
      rd_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      rvalid_q  <= rvalid_d;
      rd_q      <= rd_d;
      err_q     <= err_d;
    end
  end

  // NOTE: the array itself has no reset; the CLEAR sweep zeroes it so it can map onto plain RAM macros.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_idx] <= mem_wdata;
  end

`ifdef RAM_MMIO_EN
  logic [31:0] mmio_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mmio_q <= '0;
    end else if (state_q == ST_IDLE && req && we && !misaligned && mmio_sel) begin
      mmio_q <= merge_lanes(mmio_q, wd, be);
    end
  end

  assign mmio_rdata = mmio_q;
`else
  assign mmio_rdata = '0;
`endif

  assign toggle_value = mmio_rdata;
  assign ready        = (state_q == ST_IDLE);
  assign rvalid       = rvalid_q;
  assign rd           = rd_q;
  assign err          = err_q;

endmodule

// File: tb/tb_ram_bytes_ctrl.sv
// Directed bench for ram_bytes_ctrl: clear timing, byte lanes, back-to-back traffic, errors,
// MMIO register and reset during clear.
module tb_ram_bytes_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [3:0]  be;
  logic        ready;
  logic        rvalid;
  logic [31:0] rd;
  logic        err;
  logic [31:0] toggle_value;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_bytes_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .req          (req),
    .we           (we),
    .a            (a),
    .wd           (wd),
    .be           (be),
    .ready        (ready),
    .rvalid       (rvalid),
    .rd           (rd),
    .err          (err),
    .toggle_value (toggle_value)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge: drives one cycle of inputs and returns at the next negedge,
  // where the response to that cycle's request is visible.
  task automatic cycle(input logic r, input logic w, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] lanes);
    req = r; we = w; a = addr; wd = data; be = lanes;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Counts rising edges after reset release until ready is high; also counts rvalid pulses.
  task automatic count_clear(input logic hold_req, output int edges, output int pulses);
    edges  = 0;
    pulses = 0;
    req = hold_req; we = 1'b0; a = 32'h0; wd = 32'h0; be = 4'h0;
    while (edges < 1000) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (rvalid) pulses++;
      if (ready) break;
    end
    req = 1'b0;
  endtask

  initial begin
    int edges, pulses;
    logic exp_mmio_err;
    logic [31:0] exp_tog;

    vecs[0]  = '{"rd_0x000",      1'b0, 32'h0000_0000, 32'h0,          4'h0, 32'h0000_0000, 1'b0};
    vecs[1]  = '{"rd_0x1fc",      1'b0, 32'h0000_01FC, 32'h0,          4'h0, 32'h0000_0000, 1'b0};
    vecs[2]  = '{"rd_0x040",      1'b0, 32'h0000_0040, 32'h0,          4'h0, 32'h0000_0000, 1'b0};
    vecs[3]  = '{"wr_3c_full",    1'b1, 32'h0000_003C, 32'h0000_0000,  4'hF, 32'h0000_0000, 1'b0};
    vecs[4]  = '{"wr_3c_be0101",  1'b1, 32'h0000_003C, 32'hAABB_CCDD,  4'h5, 32'h00BB_00DD, 1'b0};
    vecs[5]  = '{"rd_3c",         1'b0, 32'h0000_003C, 32'h0,          4'h0, 32'h00BB_00DD, 1'b0};
    vecs[6]  = '{"wr_10",         1'b1, 32'h0000_0010, 32'h1234_5678,  4'hF, 32'h1234_5678, 1'b0};
    vecs[7]  = '{"raw_rd_10",     1'b0, 32'h0000_0010, 32'h0,          4'hF, 32'h1234_5678, 1'b0};
    vecs[8]  = '{"rd_misaligned", 1'b0, 32'h0000_0011, 32'h0,          4'h0, 32'h0000_0000, 1'b1};
    vecs[9]  = '{"wr_oor_200",    1'b1, 32'h0000_0200, 32'hFFFF_FFFF,  4'hF, 32'h0000_0000, 1'b1};
    vecs[10] = '{"rd_0_after_err",1'b0, 32'h0000_0000, 32'h0,          4'h0, 32'h0000_0000, 1'b0};
    vecs[11] = '{"wr_20_be0",     1'b1, 32'h0000_0020, 32'h1122_3344,  4'h0, 32'h0000_0000, 1'b0};
    vecs[12] = '{"wr_20_be1010",  1'b1, 32'h0000_0020, 32'h1122_3344,  4'hA, 32'h1100_3300, 1'b0};
    vecs[13] = '{"wr_20_be0011",  1'b1, 32'h0000_0020, 32'h5566_7788,  4'h3, 32'h1100_7788, 1'b0};
    vecs[14] = '{"rd_20",         1'b0, 32'h0000_0020, 32'h0,          4'h0, 32'h1100_7788, 1'b0};
    vecs[15] = '{"wr_1fc",        1'b1, 32'h0000_01FC, 32'hDEAD_BEEF,  4'hF, 32'hDEAD_BEEF, 1'b0};

    resetn = 1'b0;
    req = 1'b0; we = 1'b0; a = 32'h0; wd = 32'h0; be = 4'h0;
    repeat (3) @(negedge clk);
    check("reset_ready",  {31'h0, ready},  32'h0);
    check("reset_rvalid", {31'h0, rvalid}, 32'h0);
    check("reset_rd",     rd,              32'h0);
    check("reset_err",    {31'h0, err},    32'h0);
    check("reset_toggle", toggle_value,    32'h0);

    resetn = 1'b1;
    count_clear(1'b0, edges, pulses);
    check("clear_edges", 32'(edges), 32'd128);

    // Vectors run with req held high, so every row is back-to-back with the previous one.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, vecs[i].we, vecs[i].a, vecs[i].wd, vecs[i].be);
      check({vecs[i].name, "_rvalid"}, {31'h0, rvalid}, 32'h1);
      check({vecs[i].name, "_rd"},     rd,              vecs[i].exp_rd);
      check({vecs[i].name, "_err"},    {31'h0, err},    {31'h0, vecs[i].exp_err});
    end

    cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check("idle_rvalid_low", {31'h0, rvalid}, 32'h0);
    check("idle_rd_hold",    rd,              32'hDEAD_BEEF);

`ifdef RAM_MMIO_EN
    exp_mmio_err = 1'b0;
    exp_tog      = 32'h1;
`else
    exp_mmio_err = 1'b1;
    exp_tog      = 32'h0;
`endif
    cycle(1'b1, 1'b1, 32'h0000_1000, 32'h0000_0001, 4'hF);
    check("mmio_wr1_err",    {31'h0, err}, {31'h0, exp_mmio_err});
    check("mmio_wr1_rd",     rd,           exp_tog);
    check("mmio_wr1_toggle", toggle_value, exp_tog);
    cycle(1'b1, 1'b1, 32'h0000_1000, 32'h0000_0000, 4'hF);
    check("mmio_wr0_err",    {31'h0, err}, {31'h0, exp_mmio_err});
    check("mmio_wr0_toggle", toggle_value, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Reset at clear cycle 50, with req held high through both clears.
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    req = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    check("midclear_rvalid_before", {31'h0, rvalid}, 32'h0);
    resetn = 1'b0;
    #1;
    check("midclear_async_ready", {31'h0, ready}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    count_clear(1'b1, edges, pulses);
    check("midclear_edges",  32'(edges),  32'd128);
    check("midclear_pulses", 32'(pulses), 32'd0);

    cycle(1'b1, 1'b0, 32'h0000_01FC, 32'h0, 4'h0);
    check("recleared_1fc_rd",  rd,           32'h0);
    check("recleared_1fc_err", {31'h0, err}, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
